// File: rtl/rename_pkg.sv
// rename_pkg: shared sizes, tag types and the identity reset map for the checkpointed rename map.
package rename_pkg;
  localparam int ARCH_COUNT = 32;
  localparam int PHYS_COUNT = 128;
  localparam int WIDTH = 4;
  localparam int CKPT_COUNT = 4;
  localparam int ARCH_W = $clog2(ARCH_COUNT);
  localparam int PHYS_W = $clog2(PHYS_COUNT);
  localparam int CKPT_W = $clog2(CKPT_COUNT);
  localparam int LANE_W = $clog2(WIDTH);
  localparam logic [CKPT_W:0] CKPT_FULL = (CKPT_W + 1)'(CKPT_COUNT);
  typedef logic [ARCH_W-1:0] arch_idx_t;
  typedef logic [PHYS_W-1:0] phys_idx_t;
  typedef logic [CKPT_W-1:0] ckpt_id_t;
  typedef phys_idx_t [ARCH_COUNT-1:0] map_t;
  function automatic map_t identity_map();
    map_t m;
    for (int i = 0; i < ARCH_COUNT; i++) m[i] = phys_idx_t'(i);
    return m;
  endfunction
endpackage

// File: rtl/rename_bypass.sv
// rename_bypass: per-lane source/old-tag lookup with priority bypass from earlier lanes of the group.
module rename_bypass
  import rename_pkg::*;
#(
  parameter bit ZERO_REG_EN = 1'b1
) (
  input  logic [WIDTH-2:0]             we,
  input  arch_idx_t [WIDTH-1:0]        dst_arch,
  input  phys_idx_t [WIDTH-2:0]        dst_phys,
  input  arch_idx_t [WIDTH-1:0][1:0]   src_arch,
  input  map_t                         map,
  output phys_idx_t [WIDTH-1:0][1:0]   src_phys,
  output phys_idx_t [WIDTH-1:0]        old_phys
);
  for (genvar l = 0; l < WIDTH; l++) begin : g_lane
    // s==2 is the destination lookup that yields the old tag
    for (genvar s = 0; s < 3; s++) begin : g_q
      arch_idx_t a;
      phys_idx_t r;
      if (s == 2) begin : g_dst
        assign a = dst_arch[l];
        assign old_phys[l] = r;
      end else begin : g_src
        assign a = src_arch[l][s];
        assign src_phys[l][s] = r;
      end
      always_comb begin
        r = map[a];
        for (int j = 0; j < l; j++) if (we[j] && dst_arch[j] == a) r = dst_phys[j];
        if (ZERO_REG_EN && a == '0) r = '0;
      end
    end
  end
endmodule

// File: rtl/ckpt_rename_map.sv
// ckpt_rename_map: superscalar arch-to-phys rename map with a circular buffer of branch checkpoints.
module ckpt_rename_map
  import rename_pkg::*;
#(
  parameter bit ZERO_REG_EN = 1'b1
) (
  input  logic                         clk,
  input  logic                         sync_rst,
  input  logic                         clk_en,
  input  logic [WIDTH-1:0]             ren_valid,
  output logic                         ren_ready,
  input  logic [WIDTH-1:0]             ren_dst_en,
  input  arch_idx_t [WIDTH-1:0]        ren_dst_arch,
  input  phys_idx_t [WIDTH-1:0]        ren_dst_phys,
  input  arch_idx_t [WIDTH-1:0][1:0]   ren_src_arch,
  input  logic                         ckpt_req,
  input  logic [LANE_W-1:0]            ckpt_lane,
  output logic [WIDTH-1:0]             out_valid,
  output phys_idx_t [WIDTH-1:0][1:0]   out_src_phys,
  output phys_idx_t [WIDTH-1:0]        out_old_phys,
  output ckpt_id_t                     out_ckpt_id,
  input  logic                         recover_en,
  input  ckpt_id_t                     recover_id,
  input  logic                         release_en,
  output logic [CKPT_W:0]              ckpt_count
);
  if (PHYS_COUNT < ARCH_COUNT) begin : g_bad_cfg
    $error("PHYS_COUNT must be >= ARCH_COUNT");
  end
  map_t map_q, map_n, ckpt_map;
  map_t slots [CKPT_COUNT];
  ckpt_id_t head, tail;
  logic [WIDTH-1:0] we;
  logic accept, alloc, rel;
  phys_idx_t [WIDTH-1:0][1:0] src_phys;
  phys_idx_t [WIDTH-1:0] old_phys;
  // full check uses the registered count, so a same-cycle release cannot unblock allocation
  assign ren_ready = clk_en & ~recover_en & ~(ckpt_req & (ckpt_count == CKPT_FULL));
  assign accept = ren_ready & |ren_valid;
  assign alloc = accept & ckpt_req;
  assign rel = clk_en & release_en & ~recover_en & (ckpt_count != '0);
  always_comb begin
    we = ren_valid & ren_dst_en;
    for (int i = 0; i < WIDTH; i++) if (ZERO_REG_EN && ren_dst_arch[i] == '0) we[i] = 1'b0;
  end
  // highest lane wins; the snapshot is taken right after the branch lane is applied
  always_comb begin
    map_n = map_q;
    ckpt_map = map_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (we[i]) map_n[ren_dst_arch[i]] = ren_dst_phys[i];
      if (i == int'(ckpt_lane)) ckpt_map = map_n;
    end
  end
  rename_bypass #(.ZERO_REG_EN(ZERO_REG_EN)) u_bypass (
    .we       (we[WIDTH-2:0]),
    .dst_arch (ren_dst_arch),
    .dst_phys (ren_dst_phys[WIDTH-2:0]),
    .src_arch (ren_src_arch),
    .map      (map_q),
    .src_phys (src_phys),
    .old_phys (old_phys)
  );
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      map_q <= identity_map();
      head <= '0;
      tail <= '0;
      ckpt_count <= '0;
      out_valid <= '0;
      out_src_phys <= '0;
      out_old_phys <= '0;
      out_ckpt_id <= '0;
    end else if (clk_en) begin
      head <= head + ckpt_id_t'(rel);
      if (recover_en) begin
        map_q <= slots[recover_id];
        tail <= recover_id + 1'b1;
        ckpt_count <= {1'b0, ckpt_id_t'(recover_id - head)} + 1'b1;
        out_valid <= '0;
      end else begin
        ckpt_count <= ckpt_count + (CKPT_W + 1)'(alloc) - (CKPT_W + 1)'(rel);
        out_valid <= accept ? ren_valid : '0;
        if (accept) begin
          map_q <= map_n;
          out_src_phys <= src_phys;
          out_old_phys <= old_phys;
          out_ckpt_id <= tail;
        end
        if (alloc) tail <= tail + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!sync_rst && alloc) slots[tail] <= ckpt_map;
  end
  always_ff @(posedge clk) begin
    if (!sync_rst && clk_en) begin
      if (recover_en) assert ({1'b0, ckpt_id_t'(recover_id - head)} < ckpt_count);
      if (release_en && !recover_en) assert (ckpt_count != '0);
    end
  end
endmodule

// File: tb/tb_ckpt_rename_map.sv
// tb_ckpt_rename_map: scoreboard bench for the checkpointed rename map against a behavioural model.
module tb_ckpt_rename_map;
  import rename_pkg::*;
  logic clk = 1'b0;
  logic sync_rst, clk_en, ren_ready, ckpt_req, recover_en, release_en;
  logic [3:0] ren_valid, ren_dst_en, out_valid;
  arch_idx_t [3:0] ren_dst_arch;
  phys_idx_t [3:0] ren_dst_phys;
  arch_idx_t [3:0][1:0] ren_src_arch;
  logic [1:0] ckpt_lane;
  phys_idx_t [3:0][1:0] out_src_phys;
  phys_idx_t [3:0] out_old_phys;
  ckpt_id_t out_ckpt_id, recover_id;
  logic [2:0] ckpt_count;

  typedef struct packed {
    logic [3:0] v, de;
    logic [3:0][4:0] da;
    logic [3:0][6:0] dp;
    logic [3:0][1:0][4:0] sa;
    logic ck;
    logic [1:0] cl;
  } grp_t;
  typedef struct packed {
    logic [31:0] due;
    logic [3:0] v;
    logic [3:0][1:0][6:0] src;
    logic [3:0][6:0] old;
    logic ck;
    logic [1:0] ckid;
  } exp_t;

  exp_t q[$];
  logic [6:0] mmap [32];
  logic [6:0] mslot [4][32];
  int mhead, mtail, mcnt, cyc, checks, errors;
  bit run;

  ckpt_rename_map dut (
    .clk(clk), .sync_rst(sync_rst), .clk_en(clk_en), .ren_valid(ren_valid), .ren_ready(ren_ready),
    .ren_dst_en(ren_dst_en), .ren_dst_arch(ren_dst_arch), .ren_dst_phys(ren_dst_phys),
    .ren_src_arch(ren_src_arch), .ckpt_req(ckpt_req), .ckpt_lane(ckpt_lane), .out_valid(out_valid),
    .out_src_phys(out_src_phys), .out_old_phys(out_old_phys), .out_ckpt_id(out_ckpt_id),
    .recover_en(recover_en), .recover_id(recover_id), .release_en(release_en), .ckpt_count(ckpt_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [6:0] mlook(grp_t g, int lane, logic [4:0] a);
    if (a == 0) return 7'd0;
    for (int j = lane - 1; j >= 0; j--) if (g.v[j] && g.de[j] && g.da[j] == a) return g.dp[j];
    return mmap[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mmap[i] = 7'(i);
    mhead = 0; mtail = 0; mcnt = 0;
  endtask

  // drive one cycle of inputs, advance the model and queue the expected output
  task automatic apply(output bit rdy, input grp_t g, input bit rel, input bit rec, input logic [1:0] rid, input bit ce);
    exp_t e;
    bit acc, relok;
    @(negedge clk);
    clk_en = ce; ren_valid = g.v; ren_dst_en = g.de; ren_dst_arch = g.da; ren_dst_phys = g.dp;
    ren_src_arch = g.sa; ckpt_req = g.ck; ckpt_lane = g.cl;
    release_en = rel; recover_en = rec; recover_id = rid;
    #1 rdy = ren_ready;
    acc = ce && !rec && !(g.ck && mcnt == 4) && g.v != 0;
    relok = ce && rel && !rec && mcnt > 0;
    if (ce && rec) begin
      mmap = mslot[rid];
      mcnt = ((int'(rid) - mhead) & 3) + 1;
      mtail = (int'(rid) + 1) % 4;
    end else if (acc) begin
      e = '0;
      e.due = cyc + 1; e.v = g.v; e.ck = g.ck; e.ckid = 2'(mtail);
      for (int i = 0; i < 4; i++) begin
        e.src[i][0] = mlook(g, i, g.sa[i][0]);
        e.src[i][1] = mlook(g, i, g.sa[i][1]);
        e.old[i] = mlook(g, i, g.da[i]);
      end
      q.push_back(e);
      for (int i = 0; i < 4; i++) begin
        if (g.v[i] && g.de[i] && g.da[i] != 0) mmap[g.da[i]] = g.dp[i];
        if (g.ck && i == int'(g.cl)) mslot[mtail] = mmap;
      end
      if (g.ck) begin mtail = (mtail + 1) % 4; mcnt++; end
    end
    if (relok) begin mhead = (mhead + 1) % 4; mcnt--; end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (run) begin
      if (q.size() != 0 && q[0].due == cyc) begin
        e = q.pop_front();
        checks++;
        if (out_valid !== e.v) begin errors++; $display("FAIL sb_valid got %b exp %b", out_valid, e.v); end
        for (int i = 0; i < 4; i++) if (e.v[i]) begin
          checks += 3;
          if (out_src_phys[i][0] !== e.src[i][0]) begin errors++; $display("FAIL sb_src0 lane%0d got %0d exp %0d", i, out_src_phys[i][0], e.src[i][0]); end
          if (out_src_phys[i][1] !== e.src[i][1]) begin errors++; $display("FAIL sb_src1 lane%0d got %0d exp %0d", i, out_src_phys[i][1], e.src[i][1]); end
          if (out_old_phys[i] !== e.old[i]) begin errors++; $display("FAIL sb_old lane%0d got %0d exp %0d", i, out_old_phys[i], e.old[i]); end
        end
        if (e.ck) begin
          checks++;
          if (out_ckpt_id !== e.ckid) begin errors++; $display("FAIL sb_ckid got %0d exp %0d", out_ckpt_id, e.ckid); end
        end
      end else begin
        checks++;
        if (out_valid !== 4'b0) begin errors++; $display("FAIL sb_unexpected out_valid got %b exp 0000", out_valid); end
      end
    end
  end

  task automatic test_reset();
    sync_rst = 1; clk_en = 1; ren_valid = 0; ren_dst_en = 0; ren_dst_arch = '0; ren_dst_phys = '0;
    ren_src_arch = '0; ckpt_req = 0; ckpt_lane = 0; recover_en = 0; recover_id = 0; release_en = 0;
    repeat (3) @(posedge clk);
    #1;
    checks += 5;
    if (out_valid !== 4'b0) begin errors++; $display("FAIL rst_valid got %b exp 0000", out_valid); end
    if (out_ckpt_id !== 2'd0) begin errors++; $display("FAIL rst_ckid got %0d exp 0", out_ckpt_id); end
    if (ckpt_count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", ckpt_count); end
    if (out_src_phys !== '0) begin errors++; $display("FAIL rst_src got %h exp 0", out_src_phys); end
    if (out_old_phys !== '0) begin errors++; $display("FAIL rst_old got %h exp 0", out_old_phys); end
    @(negedge clk);
    sync_rst = 0;
    model_reset();
    #1 checks++;
    if (ren_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", ren_ready); end
    run = 1;
  endtask

  task automatic test_basic();
    grp_t g;
    bit r;
    g = '0; g.v = 4'b0001; g.sa[0][0] = 5; g.sa[0][1] = 6;
    apply(r, g, 0, 0, 0, 1);
    checks += 3;
    if (out_valid !== 4'b0001) begin errors++; $display("FAIL basic_valid got %b exp 0001", out_valid); end
    if (out_src_phys[0][0] !== 7'd5) begin errors++; $display("FAIL basic_src0 got %0d exp 5", out_src_phys[0][0]); end
    if (out_src_phys[0][1] !== 7'd6) begin errors++; $display("FAIL basic_src1 got %0d exp 6", out_src_phys[0][1]); end
  endtask

  task automatic test_bypass();
    grp_t g;
    bit r;
    g = '0; g.v = 4'b0111; g.de = 4'b0011;
    g.da[0] = 3; g.dp[0] = 40; g.sa[1][0] = 3; g.da[1] = 3; g.dp[1] = 41; g.sa[2][0] = 3;
    apply(r, g, 0, 0, 0, 1);
    checks += 4;
    if (out_src_phys[1][0] !== 7'd40) begin errors++; $display("FAIL byp_l1src got %0d exp 40", out_src_phys[1][0]); end
    if (out_old_phys[1] !== 7'd40) begin errors++; $display("FAIL byp_l1old got %0d exp 40", out_old_phys[1]); end
    if (out_src_phys[2][0] !== 7'd41) begin errors++; $display("FAIL byp_l2src got %0d exp 41", out_src_phys[2][0]); end
    if (out_old_phys[0] !== 7'd3) begin errors++; $display("FAIL byp_l0old got %0d exp 3", out_old_phys[0]); end
    g = '0; g.v = 4'b0001; g.sa[0][0] = 3;
    apply(r, g, 0, 0, 0, 1);
    checks++;
    if (out_src_phys[0][0] !== 7'd41) begin errors++; $display("FAIL byp_map3 got %0d exp 41", out_src_phys[0][0]); end
  endtask

  task automatic test_ckpt_recover();
    grp_t g;
    bit r;
    g = '0; g.v = 4'hF; g.de = 4'hF; g.ck = 1; g.cl = 1;
    g.da[0] = 1; g.dp[0] = 50; g.da[1] = 2; g.dp[1] = 51; g.da[2] = 1; g.dp[2] = 52; g.da[3] = 4; g.dp[3] = 53;
    apply(r, g, 0, 0, 0, 1);
    checks += 3;
    if (out_ckpt_id !== 2'd0) begin errors++; $display("FAIL ck_id got %0d exp 0", out_ckpt_id); end
    if (ckpt_count !== 3'd1) begin errors++; $display("FAIL ck_count got %0d exp 1", ckpt_count); end
    if (out_old_phys[2] !== 7'd50) begin errors++; $display("FAIL ck_chainold got %0d exp 50", out_old_phys[2]); end
    g = '0;
    apply(r, g, 0, 1, 0, 1);
    checks += 2;
    if (ckpt_count !== 3'd1) begin errors++; $display("FAIL rec_count got %0d exp 1", ckpt_count); end
    if (out_valid !== 4'b0) begin errors++; $display("FAIL rec_valid got %b exp 0000", out_valid); end
    g = '0; g.v = 4'b0111; g.sa[0][0] = 1; g.sa[1][0] = 2; g.sa[2][0] = 4;
    apply(r, g, 0, 0, 0, 1);
    checks += 3;
    if (out_src_phys[0][0] !== 7'd50) begin errors++; $display("FAIL rec_r1 got %0d exp 50", out_src_phys[0][0]); end
    if (out_src_phys[1][0] !== 7'd51) begin errors++; $display("FAIL rec_r2 got %0d exp 51", out_src_phys[1][0]); end
    if (out_src_phys[2][0] !== 7'd4) begin errors++; $display("FAIL rec_r4 got %0d exp 4", out_src_phys[2][0]); end
  endtask

  task automatic test_full();
    grp_t g;
    bit r;
    for (int k = 0; k < 3; k++) begin
      g = '0; g.v = 1; g.de = 1; g.da[0] = 7; g.dp[0] = 7'(70 + k); g.ck = 1;
      apply(r, g, 0, 0, 0, 1);
    end
    checks++;
    if (ckpt_count !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", ckpt_count); end
    g = '0; g.v = 1; g.de = 1; g.da[0] = 7; g.dp[0] = 99; g.ck = 1;
    apply(r, g, 0, 0, 0, 1);
    checks += 2;
    if (r !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", r); end
    if (out_valid !== 4'b0) begin errors++; $display("FAIL full_valid got %b exp 0000", out_valid); end
    apply(r, g, 1, 0, 0, 1);
    checks += 2;
    if (r !== 1'b0) begin errors++; $display("FAIL fullrel_ready got %b exp 0", r); end
    if (ckpt_count !== 3'd3) begin errors++; $display("FAIL fullrel_count got %0d exp 3", ckpt_count); end
    g = '0; g.v = 1; g.sa[0][0] = 7;
    apply(r, g, 0, 0, 0, 1);
    checks++;
    if (out_src_phys[0][0] !== 7'd72) begin errors++; $display("FAIL full_map7 got %0d exp 72", out_src_phys[0][0]); end
    g = '0; g.v = 1; g.de = 1; g.da[0] = 7; g.dp[0] = 88; g.ck = 1;
    apply(r, g, 0, 0, 0, 1);
    checks += 2;
    if (out_ckpt_id !== 2'd0) begin errors++; $display("FAIL wrap_id got %0d exp 0", out_ckpt_id); end
    if (ckpt_count !== 3'd4) begin errors++; $display("FAIL wrap_count got %0d exp 4", ckpt_count); end
  endtask

  task automatic test_recover_priority();
    grp_t g;
    bit r;
    g = '0; g.v = 4'b0011; g.de = 1; g.da[0] = 9; g.dp[0] = 101;
    apply(r, g, 1, 1, 2, 1);
    checks += 3;
    if (r !== 1'b0) begin errors++; $display("FAIL rp_ready got %b exp 0", r); end
    if (out_valid !== 4'b0) begin errors++; $display("FAIL rp_valid got %b exp 0000", out_valid); end
    if (ckpt_count !== 3'd2) begin errors++; $display("FAIL rp_count got %0d exp 2", ckpt_count); end
    g = '0; g.v = 1; g.sa[0][0] = 7; g.sa[0][1] = 9; g.ck = 1;
    apply(r, g, 0, 0, 0, 1);
    checks += 4;
    if (out_ckpt_id !== 2'd3) begin errors++; $display("FAIL rp_tail got %0d exp 3", out_ckpt_id); end
    if (ckpt_count !== 3'd3) begin errors++; $display("FAIL rp_count2 got %0d exp 3", ckpt_count); end
    if (out_src_phys[0][0] !== 7'd71) begin errors++; $display("FAIL rp_map7 got %0d exp 71", out_src_phys[0][0]); end
    if (out_src_phys[0][1] !== 7'd9) begin errors++; $display("FAIL rp_map9 got %0d exp 9", out_src_phys[0][1]); end
  endtask

  task automatic test_zero();
    grp_t g;
    bit r;
    g = '0; g.v = 4'b0011; g.de = 1; g.da[0] = 0; g.dp[0] = 60; g.sa[1][0] = 0; g.sa[1][1] = 0;
    apply(r, g, 0, 0, 0, 1);
    checks += 3;
    if (out_old_phys[0] !== 7'd0) begin errors++; $display("FAIL zero_old got %0d exp 0", out_old_phys[0]); end
    if (out_src_phys[1][0] !== 7'd0) begin errors++; $display("FAIL zero_src0 got %0d exp 0", out_src_phys[1][0]); end
    if (out_src_phys[1][1] !== 7'd0) begin errors++; $display("FAIL zero_src1 got %0d exp 0", out_src_phys[1][1]); end
    g = '0; g.v = 1; g.sa[0][0] = 0;
    apply(r, g, 0, 0, 0, 1);
    checks++;
    if (out_src_phys[0][0] !== 7'd0) begin errors++; $display("FAIL zero_map0 got %0d exp 0", out_src_phys[0][0]); end
  endtask

  task automatic test_stall();
    grp_t g;
    bit r;
    logic [2:0] c0;
    g = '0;
    apply(r, g, 0, 0, 0, 1);
    c0 = ckpt_count;
    g = '0; g.v = 1; g.de = 1; g.da[0] = 9; g.dp[0] = 100; g.ck = 1;
    apply(r, g, 1, 0, 0, 0);
    checks += 3;
    if (r !== 1'b0) begin errors++; $display("FAIL stall_ready got %b exp 0", r); end
    if (out_valid !== 4'b0) begin errors++; $display("FAIL stall_valid got %b exp 0000", out_valid); end
    if (ckpt_count !== c0) begin errors++; $display("FAIL stall_count got %0d exp %0d", ckpt_count, c0); end
    g = '0; g.v = 1; g.sa[0][0] = 9;
    apply(r, g, 0, 0, 0, 1);
    checks++;
    if (out_src_phys[0][0] !== 7'd9) begin errors++; $display("FAIL stall_map9 got %0d exp 9", out_src_phys[0][0]); end
  endtask

  task automatic test_back_to_back();
    grp_t g;
    bit r, rel, rec, er;
    logic [1:0] rid;
    for (int n = 0; n < 80; n++) begin
      g = '0;
      g.v = 4'($urandom); g.de = 4'($urandom); g.dp = 28'($urandom); g.da = 20'($urandom);
      g.sa = 40'({$urandom, $urandom}); g.ck = ($urandom_range(0, 2) == 0); g.cl = 2'($urandom);
      rel = mcnt > 0 && $urandom_range(0, 3) == 0;
      rec = mcnt > 0 && $urandom_range(0, 7) == 0;
      rid = rec ? 2'((mhead + $urandom_range(0, mcnt - 1)) % 4) : 2'd0;
      er = !rec && !(g.ck && mcnt == 4);
      apply(r, g, rel, rec, rid, 1);
      checks += 2;
      if (r !== er) begin errors++; $display("FAIL b2b_ready it%0d got %b exp %b", n, r, er); end
      if (ckpt_count !== 3'(mcnt)) begin errors++; $display("FAIL b2b_count it%0d got %0d exp %0d", n, ckpt_count, mcnt); end
    end
    g = '0;
    apply(r, g, 0, 0, 0, 1);
  endtask

  task automatic test_reset_mid();
    grp_t g;
    bit r;
    g = '0; g.v = 1; g.de = 1; g.da[0] = 3; g.dp[0] = 77;
    apply(r, g, 0, 0, 0, 1);
    @(negedge clk);
    sync_rst = 1; recover_en = 1; recover_id = 0; ren_valid = 4'hF;
    @(negedge clk);
    sync_rst = 0; recover_en = 0; ren_valid = 0; ren_dst_en = 0;
    model_reset();
    #1 checks += 2;
    if (ckpt_count !== 3'd0) begin errors++; $display("FAIL mrst_count got %0d exp 0", ckpt_count); end
    if (out_valid !== 4'b0) begin errors++; $display("FAIL mrst_valid got %b exp 0000", out_valid); end
    g = '0; g.v = 4'b0011; g.sa[0][0] = 3; g.sa[1][0] = 1;
    apply(r, g, 0, 0, 0, 1);
    checks += 2;
    if (out_src_phys[0][0] !== 7'd3) begin errors++; $display("FAIL mrst_map3 got %0d exp 3", out_src_phys[0][0]); end
    if (out_src_phys[1][0] !== 7'd1) begin errors++; $display("FAIL mrst_map1 got %0d exp 1", out_src_phys[1][0]); end
    g = '0;
    apply(r, g, 0, 0, 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    run = 0; checks = 0; errors = 0; cyc = 0;
    test_reset();
    test_basic();
    test_bypass();
    test_ckpt_recover();
    test_full();
    test_recover_priority();
    test_zero();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d exp 0", q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ckpt_rename_map.md
Name: ckpt_rename_map

Overview:
- Superscalar register rename map table with branch checkpoints; successor to the basic arch-to-phys map table.
- Renames up to WIDTH instructions per cycle, with intra-group dependency bypass and same-group write-after-write resolution.
- Snapshots the map into a circular checkpoint buffer on branches and restores it in one cycle on mispredict recovery.
- Sits between decode and dispatch; the free list supplies new physical tags, and the ROB consumes the old tags.

Parameters:
ARCH_COUNT, 32, architectural registers
PHYS_COUNT, 128, physical registers; must be >= ARCH_COUNT
WIDTH, 4, rename lanes per cycle
CKPT_COUNT, 4, checkpoint slots; power of two
ZERO_REG_EN, 1, when 1, arch reg 0 is never renamed and always reads phys 0
ARCH_W, $clog2(ARCH_COUNT), arch index width
PHYS_W, $clog2(PHYS_COUNT), phys tag width
CKPT_W, $clog2(CKPT_COUNT), checkpoint id width

Ports:
clk  in  1  clock
sync_rst  in  1  synchronous reset, active-high
clk_en  in  1  global stall; when low, all state and outputs hold
ren_valid  in  WIDTH  lane carries an instruction
ren_ready  out  1  group accepted this cycle (combinational)
ren_dst_en  in  WIDTH  lane writes a destination
ren_dst_arch  in  ARCH_W x WIDTH  destination arch reg
ren_dst_phys  in  PHYS_W x WIDTH  new tag from the free list
ren_src_arch  in  ARCH_W x 2 x WIDTH  two source arch regs per lane
ckpt_req  in  1  group contains a branch needing a snapshot
ckpt_lane  in  $clog2(WIDTH)  lane of that branch
out_valid  out  WIDTH  registered renamed lanes
out_src_phys  out  PHYS_W x 2 x WIDTH  source tags
out_old_phys  out  PHYS_W x WIDTH  previous mapping of the destination (freed at commit)
out_ckpt_id  out  CKPT_W  id allocated to this group's checkpoint
recover_en  in  1  mispredict; restore checkpoint
recover_id  in  CKPT_W  checkpoint to restore
release_en  in  1  oldest checkpoint resolved correct; free it
ckpt_count  out  CKPT_W+1  occupied checkpoint slots

Behaviour:
- Reset (sync_rst=1 at clk edge):
  - map[i]=i for all i.
  - out_valid=0; out_src_phys, out_old_phys and out_ckpt_id are 0.
  - Checkpoint head=tail=0; ckpt_count=0.
  - Reset overrides every other input, including an in-flight recover.
- Latency: 1 cycle. Outputs are registered at the edge where the group is accepted.
- Acceptance:
  - ren_ready = clk_en & !recover_en & !(ckpt_req & ckpt_count==CKPT_COUNT).
  - The group is applied only if ren_ready and at least one ren_valid bit is set.
  - When not accepted, the map is unchanged and out_valid=0 next cycle.
- Source lookup, lane i:
  - Take the highest lane j<i with valid, dst_en and dst_arch==src, and use its ren_dst_phys.
  - If no such lane exists, use map[src].
- out_old_phys[i] uses the same rule applied to dst_arch, so it chains through earlier lanes in the group.
- Map update: for each arch reg, the highest valid dst_en lane writing it wins.
- Zero register: with ZERO_REG_EN, dst_arch==0 writes are dropped and out_old_phys=0; src 0 returns 0 with no bypass.
- Checkpoint:
  - On an accepted group with ckpt_req, slot[tail] is written with the map after lanes 0..ckpt_lane are applied. Later lanes in the group are excluded.
  - out_ckpt_id=tail; tail increments modulo CKPT_COUNT; count increments.
- Recover:
  - Has priority over rename; ren_ready=0 that cycle.
  - map <= slot[recover_id]; tail <= recover_id+1 (wrapping); count recomputed as tail-head (0 < count <= CKPT_COUNT).
  - recover_id must be an occupied slot; behaviour for an unoccupied id is undefined and flagged by an assertion.
  - Registered outputs clear (out_valid=0).
- Release: head increments and count decrements. Ignored when count==0 or when recover_en is high in the same cycle (the requester re-asserts).
- Simultaneous release and checkpoint allocation: both apply, and count is unchanged. At full, release in the same cycle does not unblock allocation; the full check uses the registered count.
- Wrap-around: head and tail wrap modulo CKPT_COUNT. Full versus empty is distinguished by ckpt_count, not by head==tail.
- Assertions: PHYS_COUNT>=ARCH_COUNT; recover_id occupied; no release when empty.

Decomposition:
- Package rename_pkg:
  - arch_idx_t, phys_idx_t, ckpt_id_t typedefs.
  - map_t (array of phys_idx_t sized ARCH_COUNT).
  - function for the identity reset map.
- Sub-module rename_bypass: combinational per-lane priority lookup of src/old tags against earlier lanes. Instanced once; generate over lanes.
- The checkpoint ring stays inline.

Test Plan:
- Reset, then rename lane0 src r5,r6 -> out_src_phys=5,6 next cycle; out_valid=0001.
- Group: lane0 r3<-p40, lane1 src r3 and r3<-p41, lane2 src r3 -> lane1 src=40 and old=40; lane2 src=41; then map[3]=41.
- ckpt_req with ckpt_lane=1, lanes 0-3 writing r1<-p50, r2<-p51, r1<-p52, r4<-p53, then recover to that id -> map r1=50, r2=51, r4=4; ckpt_count=1.
- Allocate 4 checkpoints -> ckpt_count=4. Fifth ckpt_req gives ren_ready=0 and map unchanged. Release in that cycle -> allocation succeeds the next cycle with out_ckpt_id=0 (wrap).
- recover_en together with release_en and a valid group -> group rejected, release ignored, out_valid=0, tail=recover_id+1.
- ZERO_REG_EN=1: lane writes r0<-p60 and lane reads r0 -> src=0, old=0, map[0] stays 0; sync_rst asserted mid-stream restores the identity map.
